// File: rtl/sync_fifo_pkg.sv
// Shared constants for the synchronous FIFO family and its drain-side reader.
package sync_fifo_pkg;

    // The FIFO RAM returns read data one cycle after an accepted pop.
    localparam int FIFO_RD_LATENCY = 1;

    // Entries in the reader's skid buffer. Two entries are enough to cover
    // one word in flight plus one word held under backpressure.
    localparam int SKID_DEPTH = 2;

    // Skid buffer occupancy, 0..SKID_DEPTH.
    typedef logic [1:0] occ_t;

endpackage

// File: rtl/sync_fifo_reader_if.sv
// FIFO read port plus outgoing valid/ready stream, bundled for the reader.
interface sync_fifo_reader_if #(
    parameter int WIDTH = 64
);

    logic             fifo_empty;
    logic             fifo_rden;
    logic [WIDTH-1:0] fifo_rddata;

    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    // The reader pops the FIFO and sources the stream.
    modport master (
        input  fifo_empty,
        input  fifo_rddata,
        input  m_ready,
        output fifo_rden,
        output m_valid,
        output m_data,
        output m_last
    );

    // The FIFO and the stream sink together sit on this side.
    modport slave (
        output fifo_empty,
        output fifo_rddata,
        output m_ready,
        input  fifo_rden,
        input  m_valid,
        input  m_data,
        input  m_last
    );

endinterface

// File: rtl/sync_fifo_reader_skid_buf.sv
// Two-entry in-order skid buffer. entry0 is always the head; a pop shifts
// entry1 forward, and a push lands in the first slot left free after the pop.
module stream_skid_buf
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output occ_t             occ,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] second
);

    occ_t             occ_q;
    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             wr_second;

    // A push goes into slot (occ - pop): slot 1 only when one entry remains after the pop.
    assign wr_second = ((occ_q == 2'd1) && !pop) || ((occ_q == 2'd2) && pop);

    assign occ    = occ_q;
    assign head   = entry0;
    assign second = entry1;

    // Occupancy tracks pushes minus pops; contents need no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Shift on pop, then write the incoming word behind whatever remains.
    always_ff @(posedge clk) begin
        if (pop) begin
            entry0 <= entry1;
        end
        if (push) begin
            if (wr_second) begin
                entry1 <= push_data;
            end else begin
                entry0 <= push_data;
            end
        end
    end

    // Guard against overflow, underflow and occupancy escaping its range.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (occ_q <= 2'(SKID_DEPTH));
            assert (!(push && !pop && (occ_q == 2'(SKID_DEPTH))));
            assert (!(pop && (occ_q == 2'd0)));
        end
    end

endmodule

// File: rtl/sync_fifo_reader.sv
// Drain-side reader for the synchronous FIFO: pops words through the
// registered read port and presents them as a valid/ready stream framed
// into BURST_LEN-beat bursts. Pops are issued only when the skid buffer is
// guaranteed to have a slot when the data arrives one cycle later.
module sync_fifo_reader
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int BURST_LEN = 16
) (
    input  logic                clk,
    input  logic                rst,
    sync_fifo_reader_if.master  bus,
    output logic                idle
);

    localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    occ_t              occ;
    logic              inflight;
    logic [BEAT_W-1:0] beat;
    logic [WIDTH-1:0]  head;
    logic [WIDTH-1:0]  second;
    logic [2:0]        committed;
    logic              valid;
    logic              hs;
    logic              rden;

    // Words already owned by the reader: buffered plus the one arriving next cycle.
    assign committed = {1'b0, occ} + {2'b00, inflight};

    assign valid = (occ != 2'd0);
    assign hs    = valid && bus.m_ready;

    // A handshake this cycle frees a slot, so a pop may be issued even when full.
    assign rden = !rst && !bus.fifo_empty && ((committed < 3'(SKID_DEPTH)) || hs);

    assign bus.fifo_rden = rden;
    assign bus.m_valid   = valid;
    assign bus.m_data    = head;
    assign bus.m_last    = valid && (beat == LAST_BEAT);
    assign idle          = (occ == 2'd0) && !inflight;

    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (bus.fifo_rddata),
        .pop       (hs),
        .occ       (occ),
        .head      (head),
        .second    (second)
    );

    // Remember that a pop was accepted so its data is captured next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rden;
        end
    end

    // Count handshaked beats within the burst; held while the stream stalls or starves.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat <= '0;
        end else if (hs) begin
            beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
        end
    end

    // After a handshake from a full buffer, the old second entry must become the head.
    assert property (@(posedge clk) disable iff (rst)
        (hs && (occ == 2'd2)) |=> (head == $past(second)));

endmodule
